// File: rtl/put_in_order_chan_fifo.sv
// put_in_order_chan_fifo: per-channel circular FIFO.
// Ports: clk/rst (async, active-high); push/push_data write one entry at the tail;
// pop drops the head entry; head_data is the oldest entry; count is the occupancy.
// The parent only asserts push when count != depth and pop when count != 0.
module put_in_order_chan_fifo #(
  parameter int width = 16,
  parameter int depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [width-1:0]           push_data,
  input  logic                       pop,
  output logic [width-1:0]           head_data,
  output logic [$clog2(depth+1)-1:0] count
);
  localparam int cw = $clog2(depth + 1);
  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  logic [width-1:0] r_mem [depth];
  logic [pw-1:0]    r_wp, r_rp;
  logic [cw-1:0]    r_count;
  function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
    return (p == pw'(depth - 1)) ? '0 : p + pw'(1);
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wp <= nxt(r_wp);
      if (pop) r_rp <= nxt(r_rp);
      r_count <= (push && !pop) ? r_count + cw'(1) :
                 (pop && !push) ? r_count - cw'(1) : r_count;
    end
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= push_data;
  assign head_data = r_mem[r_rp];
  assign count     = r_count;
endmodule

// File: rtl/put_in_order_buf.sv
// put_in_order_buf: merges n_inputs variable-latency result streams into one stream in strict channel order.
// Ports: clk/rst (async, active-high); up_vlds/up_data per-channel results, up_rdys per-channel space;
// down_vld/down_data/down_chan registered output with down_rdy backpressure; overflow sticky on push-to-full.
module put_in_order_buf #(
  parameter int width    = 16,
  parameter int n_inputs = 4,
  parameter int depth    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [n_inputs-1:0]                 up_vlds,
  input  logic [n_inputs-1:0][width-1:0]      up_data,
  output logic [n_inputs-1:0]                 up_rdys,
  output logic                                down_vld,
  input  logic                                down_rdy,
  output logic [width-1:0]                    down_data,
  output logic [$clog2(n_inputs)-1:0]         down_chan,
  output logic                                overflow
);
  localparam int cw = $clog2(depth + 1);
  localparam int rw = $clog2(n_inputs);
  logic [cw-1:0]       w_count [n_inputs];
  logic [width-1:0]    w_head  [n_inputs];
  logic [n_inputs-1:0] w_push, w_pop, w_full;
  logic                w_free, w_load;
  logic [rw-1:0]       r_rr, r_chan;
  logic [width-1:0]    r_data;
  logic                r_vld, r_ovf;
  // Output register can take a new value; the current channel is never skipped.
  assign w_free = !r_vld || down_rdy;
  assign w_load = w_free && (w_count[r_rr] != '0);
  for (genvar i = 0; i < n_inputs; i++) begin : g_ch
    // Fullness is judged before any same-cycle pop, so a push racing a pop is dropped.
    assign w_full[i] = (w_count[i] == cw'(depth));
    assign w_push[i] = up_vlds[i] && !w_full[i];
    assign w_pop[i]  = w_load && (r_rr == rw'(i));
    put_in_order_chan_fifo #(.width(width), .depth(depth)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push[i]),
      .push_data (up_data[i]),
      .pop       (w_pop[i]),
      .head_data (w_head[i]),
      .count     (w_count[i])
    );
  end
  assign up_rdys = ~w_full;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rr   <= '0;
      r_vld  <= 1'b0;
      r_data <= '0;
      r_chan <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (|(up_vlds & w_full)) r_ovf <= 1'b1;
      if (w_load) begin
        r_data <= w_head[r_rr];
        r_chan <= r_rr;
        r_vld  <= 1'b1;
        r_rr   <= (r_rr == rw'(n_inputs - 1)) ? '0 : r_rr + rw'(1);
      end else if (w_free) r_vld <= 1'b0;
    end
  assign down_vld  = r_vld;
  assign down_data = r_data;
  assign down_chan = r_chan;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_put_in_order_buf.sv
// tb_put_in_order_buf: directed scoreboard bench for put_in_order_buf.
module tb_put_in_order_buf;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       up_vlds = '0;
  logic [3:0][15:0] up_data = '0;
  logic [3:0]       up_rdys;
  logic             down_vld;
  logic             down_rdy = 1'b0;
  logic [15:0]      down_data;
  logic [1:0]       down_chan;
  logic             overflow;
  int               n_chk = 0;
  int               n_fail = 0;
  logic [17:0]      sb [$];
  put_in_order_buf #(.width(16), .n_inputs(4), .depth(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vlds   (up_vlds),
    .up_data   (up_data),
    .up_rdys   (up_rdys),
    .down_vld  (down_vld),
    .down_rdy  (down_rdy),
    .down_data (down_data),
    .down_chan (down_chan),
    .overflow  (overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic expect_out(input logic [1:0] ch, input logic [15:0] d);
    sb.push_back({ch, d});
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_scoreboard_left", sb.size(), 0);
  endtask
  // Monitor: every accepted output is matched against the oldest expected entry.
  always @(negedge clk)
    if (!rst && down_vld && down_rdy) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got chan %0d data %h expected nothing", down_chan, down_data);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        if ({down_chan, down_data} !== e) begin
          n_fail++;
          $display("FAIL output_order: got chan %0d data %h expected chan %0d data %h",
                   down_chan, down_data, e[17:16], e[15:0]);
        end
      end
    end
  initial begin
    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    chk("reset_up_rdys", up_rdys, 4'hf);
    for (int i = 0; i < 10; i++) begin
      chk("idle_outputs", {down_vld, overflow, down_chan, down_data}, 0);
      tick();
    end
    // Out-of-order arrival, in-order delivery
    down_rdy = 1'b1;
    expect_out(0, 16'h0000);
    expect_out(1, 16'h0011);
    expect_out(2, 16'h0022);
    expect_out(3, 16'h0033);
    up_vlds = 4'b1000; up_data[3] = 16'h0033;
    tick();
    up_vlds = 4'b0010; up_data[1] = 16'h0011;
    tick();
    up_vlds = 4'b0001; up_data[0] = 16'h0000;
    tick();
    up_vlds = 4'b0100; up_data[2] = 16'h0022;
    chk("latency_not_early", down_vld, 0);
    tick();
    up_vlds = '0;
    chk("latency_first_vld", {down_vld, down_chan}, {1'b1, 2'd0});
    drain();
    // Full-rate back-to-back fill
    for (int i = 0; i < 4; i++) expect_out(2'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) expect_out(2'(i), 16'hB000 + 16'(i));
    up_vlds = 4'hf;
    for (int i = 0; i < 4; i++) up_data[i] = 16'hA000 + 16'(i);
    tick();
    for (int i = 0; i < 4; i++) up_data[i] = 16'hB000 + 16'(i);
    tick();
    up_vlds = '0;
    for (int i = 0; i < 8; i++) begin
      chk("streaming_vld", down_vld, 1);
      tick();
    end
    chk("streaming_end", down_vld, 0);
    drain();
    // Same fill with a 5-cycle stall on the first output
    for (int i = 0; i < 4; i++) expect_out(2'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) expect_out(2'(i), 16'hB000 + 16'(i));
    up_vlds = 4'hf;
    for (int i = 0; i < 4; i++) up_data[i] = 16'hA000 + 16'(i);
    tick();
    for (int i = 0; i < 4; i++) up_data[i] = 16'hB000 + 16'(i);
    tick();
    up_vlds = '0;
    down_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {down_vld, down_chan, down_data}, {1'b1, 2'd0, 16'hA000});
      tick();
    end
    down_rdy = 1'b1;
    drain();
    // Overflow on ch0: move rr to ch1 first so ch0 cannot drain
    expect_out(0, 16'h0009);
    up_vlds = 4'b0001; up_data[0] = 16'h0009;
    tick();
    up_vlds = '0;
    drain();
    down_rdy = 1'b0;
    up_vlds = 4'b0001; up_data[0] = 16'h0001;
    tick();
    chk("ch0_rdy_after_1", up_rdys[0], 1);
    up_data[0] = 16'h0002;
    tick();
    chk("ch0_rdy_after_2", {up_rdys[0], overflow}, 2'b00);
    up_data[0] = 16'h0003;
    tick();
    up_vlds = '0;
    chk("overflow_set", {up_rdys[0], overflow}, 2'b01);
    expect_out(1, 16'h0101);
    expect_out(2, 16'h0201);
    expect_out(3, 16'h0301);
    expect_out(0, 16'h0001);
    expect_out(1, 16'h0102);
    expect_out(2, 16'h0202);
    expect_out(3, 16'h0302);
    expect_out(0, 16'h0002);
    up_vlds = 4'b1110;
    for (int i = 1; i < 4; i++) up_data[i] = 16'h0001 + 16'(i << 8);
    tick();
    for (int i = 1; i < 4; i++) up_data[i] = 16'h0002 + 16'(i << 8);
    tick();
    up_vlds = '0;
    down_rdy = 1'b1;
    drain();
    tick();
    chk("overflow_sticky", {overflow, up_rdys}, {1'b1, 4'hf});
    // Asynchronous reset with data buffered
    down_rdy = 1'b0;
    up_vlds = 4'b1110;
    up_data[1] = 16'hDEAD; up_data[2] = 16'hBEEF; up_data[3] = 16'hCAFE;
    tick();
    up_vlds = 4'b0010;
    tick();
    up_vlds = '0;
    tick();
    chk("pre_reset_vld", down_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {down_vld, overflow, up_rdys, down_data}, {1'b0, 1'b0, 4'hf, 16'h0});
    tick();
    rst = 1'b0;
    down_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_idle", down_vld, 0);
      tick();
    end
    expect_out(0, 16'h5555);
    up_vlds = 4'b0001; up_data[0] = 16'h5555;
    tick();
    up_vlds = '0;
    drain();
    tick();
    chk("final_idle", down_vld, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/put_in_order_buf.md
Name: put_in_order_buf

Overview:
- Parametrised successor to the round-robin reorder block.
- Collects results from n_inputs variable-latency compute blocks and emits them strictly in channel order 0,1,…,n_inputs-1,0,…
- Each channel has a depth-entry FIFO, and the downstream port supports valid/ready backpressure.
- Upstream receives per-channel ready signals. A sticky overflow flag reports any push to a full channel.
- Sits between the compute-block array and a single serial consumer.

Parameters:
- width, 16, data bits per result
- n_inputs, 4, number of upstream channels (>=2)
- depth, 2, FIFO entries per channel (>=1; a power of two is not required)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- up_vlds  in  n_inputs  per-channel result valid
- up_data  in  n_inputs x width  per-channel result data (packed 2-D)
- up_rdys  out  n_inputs  channel i can accept; equals (count_i != depth)
- down_vld  out  1  output valid, registered
- down_rdy  in  1  consumer accepts when down_vld & down_rdy
- down_data  out  width  output data, registered
- down_chan  out  $clog2(n_inputs)  source channel of down_data, registered
- overflow  out  1  sticky: a push arrived on a full channel

Behaviour:
- Reset (async, active-high) clears:
  - down_vld=0, down_data=0, down_chan=0, overflow=0
  - all FIFO counts and pointers = 0
  - round-robin pointer rr=0
- Reset mid-operation discards all buffered data. No output is emitted until new pushes arrive after reset deasserts.

Push rules, channel i, each cycle:
- up_vlds[i]=1 and count_i<depth: write up_data[i] at the write pointer, then increment the write pointer (wraps at depth-1).
- up_vlds[i]=1 and count_i==depth:
  - data is dropped and the FIFO is unchanged
  - overflow <= 1 and stays 1 until reset
  - this holds even if channel i pops in the same cycle; up_rdys does not look ahead to a pop
- All channels may push in the same cycle.

Output stage:
- load = (!down_vld | down_rdy) & (count_rr != 0)
- On load:
  - down_data <= head of FIFO rr; down_chan <= rr; down_vld <= 1
  - pop FIFO rr
  - rr <= (rr==n_inputs-1) ? 0 : rr+1
- If (!down_vld | down_rdy) and FIFO rr is empty: down_vld <= 0 and rr holds. The block waits on the current channel and never skips it.
- If down_vld & !down_rdy: down_vld, down_data and down_chan hold stable.

Timing:
- Latency: push in cycle t → earliest down_vld in cycle t+2. There is no bypass path.
- Throughput: 1 result/cycle while the channel under rr is non-empty and down_rdy=1.

Counts:
- Push and pop on the same channel in the same cycle leave count_i unchanged.
- count width is $clog2(depth+1).

Ordering guarantee:
- The k-th output from channel i is the k-th accepted push on channel i.
- Outputs cycle through channels in strict order.

Decomposition:
- No shared package. Widths are derived locally with $clog2.
- One sub-module: put_in_order_chan_fifo
  - parameters: width, depth
  - ports: clk, rst, push, push_data, pop, head_data, count
  - instantiated n_inputs times in a generate loop
- Top level holds the round-robin pointer, output register and overflow flag.

Test Plan:
- Reset with all inputs idle → down_vld=0, up_rdys=4'b1111, overflow=0; all outputs stay 0 for 10 cycles.
- Pushes ch3=0x0033 (t0), ch1=0x0011 (t1), ch0=0x0000 (t2), ch2=0x0022 (t3), down_rdy=1 → outputs 0x0000, 0x0011, 0x0022, 0x0033 with down_chan 0,1,2,3; first down_vld in cycle t4.
- All four channels push twice back-to-back (0xA0i then 0xB0i), down_rdy=1 → 8 consecutive valid cycles: A000, A001, A002, A003, B000, B001, B002, B003.
- Same fill, with down_rdy=0 for 5 cycles after the first down_vld → down_data stays 0xA000 throughout; the sequence resumes unchanged when down_rdy returns to 1.
- Ch0 pushes 3 times (0x1, 0x2, 0x3) with down_rdy=0 and depth=2 → up_rdys[0]=0 after the 2nd push; 0x3 is dropped; overflow=1 and stays set; the output later shows only 0x1, 0x2 from ch0.
- rst asserted asynchronously mid-stream with 3 entries buffered → down_vld drops immediately; after release, the next push on ch0=0x5555 yields down_data=0x5555, down_chan=0.
